// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the writeback stage: datapath widths,
// register-file geometry and the load-hold state encoding.
package writeback_stage_pkg;

  localparam int PIPE_DATA_W     = 16;
  localparam int PIPE_REG_ADDR_W = 3;
  localparam int NUM_REGS        = 8;
  localparam int RETIRE_W        = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/register_file_8x16.sv
// Architectural register file: async-reset array, one write port, two
// combinational read ports that see the value being written this cycle.
module register_file_8x16 #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  // r0 is hard-wired: the write port never touches entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    w_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == '0) begin
      w_rdata1 = '0;
    end else if (i_we && (i_raddr1 == i_waddr)) begin
      w_rdata1 = i_wdata;
    end
  end

  always_comb begin
    w_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == '0) begin
      w_rdata2 = '0;
    end else if (i_we && (i_raddr2 == i_waddr)) begin
      w_rdata2 = i_wdata;
    end
  end

  assign o_rdata1 = w_rdata1;
  assign o_rdata2 = w_rdata2;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, ALU/memory select, load-hold FSM
// across stalls, register-file commit with forwarding tap, retire counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  IValid,
  input  logic                  IRegWrite,
  input  logic                  IRegStore,
  input  logic [DATA_W-1:0]     IALUResult,
  input  logic [DATA_W-1:0]     IMemData,
  input  logic [REG_ADDR_W-1:0] IRd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic                  fwd_we,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [RETIRE_W-1:0]   retire_count,
  output wb_state_e             o_dbg_state
);

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_regstore;
  logic [DATA_W-1:0]     r_alu;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_hold;
  wb_state_e             r_state;
  logic [RETIRE_W-1:0]   r_retire;

  logic [DATA_W-1:0]     w_mem_sel;
  logic [DATA_W-1:0]     w_wb_data;
  logic                  w_commit;

  // A flushed slot becomes a full bubble; stall alone freezes the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_regstore <= 1'b0;
      r_alu      <= '0;
      r_rd       <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_regstore <= 1'b0;
      r_alu      <= '0;
      r_rd       <= '0;
    end else if (!stall) begin
      r_valid    <= IValid;
      r_regwrite <= IRegWrite;
      r_regstore <= IRegStore;
      r_alu      <= IALUResult;
      r_rd       <= IRd;
    end
  end

  // The memory read data is only valid in the first WB cycle, so it is
  // captured on entry to a stall and used until the release cycle commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_hold  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (stall && !flush) begin
            r_hold  <= IMemData;
            r_state <= HELD;
          end
        end
        HELD: begin
          if (flush || !stall) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire <= '0;
    end else if (r_valid && !stall) begin
      r_retire <= r_retire + RETIRE_ONE;
    end
  end

  assign w_mem_sel = (r_state == HELD) ? r_hold : IMemData;
  assign w_wb_data = r_regstore ? w_mem_sel : r_alu;
  assign w_commit  = r_valid && r_regwrite && (r_rd != '0) && !stall;

  register_file_8x16 #(
    .DATA_W   (DATA_W),
    .ADDR_W   (REG_ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_commit),
    .i_waddr  (r_rd),
    .i_wdata  (w_wb_data),
    .i_raddr1 (rs1),
    .i_raddr2 (rs2),
    .o_rdata1 (rs1_data),
    .o_rdata2 (rs2_data)
  );

  assign fwd_we       = w_commit;
  assign fwd_rd       = r_rd;
  assign fwd_data     = w_wb_data;
  assign retire_count = r_retire;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: commits, loads, r0, load-hold across
// stall, flush/stall interaction, bypass, counter wrap and async reset.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        IValid;
  logic        IRegWrite;
  logic        IRegStore;
  logic [15:0] IALUResult;
  logic [15:0] IMemData;
  logic [2:0]  IRd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        fwd_we;
  logic [2:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic [15:0] retire_count;
  wb_state_e   dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_retire = 16'h0000;

  writeback_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .IValid       (IValid),
    .IRegWrite    (IRegWrite),
    .IRegStore    (IRegStore),
    .IALUResult   (IALUResult),
    .IMemData     (IMemData),
    .IRd          (IRd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .fwd_we       (fwd_we),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .retire_count (retire_count),
    .o_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    IValid     = 1'b0;
    IRegWrite  = 1'b0;
    IRegStore  = 1'b0;
    IALUResult = 16'h0000;
    IRd        = 3'd0;
  endtask

  task automatic drive_instr(input logic rw, input logic rstore, input logic [15:0] alu, input logic [2:0] rd);
    IValid     = 1'b1;
    IRegWrite  = rw;
    IRegStore  = rstore;
    IALUResult = alu;
    IRd        = rd;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (fwd_rd !== 3'd0) begin n_fail++; $display("FAIL reset_fwd_rd: got %0d expected 0", fwd_rd); end
    n_checks++; if (fwd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_fwd_data: got %h expected 0000", fwd_data); end
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rs1_data: got %h expected 0000", rs1_data); end
    n_checks++; if (rs2_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rs2_data: got %h expected 0000", rs2_data); end
    n_checks++; if (retire_count !== 16'h0000) begin n_fail++; $display("FAIL reset_retire: got %h expected 0000", retire_count); end
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL reset_state: got %0d expected RUN", dbg_state); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_retire = 16'h0000;
  endtask

  task automatic test_alu_wb();
    drive_instr(1'b1, 1'b0, 16'h1234, 3'd3);
    rs1 = 3'd3;
    step();
    drive_idle();
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b1) begin n_fail++; $display("FAIL alu_fwd_we: got %0b expected 1", fwd_we); end
    n_checks++; if (fwd_rd !== 3'd3) begin n_fail++; $display("FAIL alu_fwd_rd: got %0d expected 3", fwd_rd); end
    n_checks++; if (fwd_data !== 16'h1234) begin n_fail++; $display("FAIL alu_fwd_data: got %h expected 1234", fwd_data); end
    n_checks++; if (rs1_data !== 16'h1234) begin n_fail++; $display("FAIL alu_bypass: got %h expected 1234", rs1_data); end
    step();
    exp_retire = exp_retire + 16'd1;
    @(negedge clk);
    n_checks++; if (rs1_data !== 16'h1234) begin n_fail++; $display("FAIL alu_array: got %h expected 1234", rs1_data); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL alu_after_we: got %0b expected 0", fwd_we); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL alu_retire: got %h expected %h", retire_count, exp_retire); end
  endtask

  task automatic test_load_wb();
    drive_instr(1'b1, 1'b1, 16'h1111, 3'd5);
    rs2 = 3'd5;
    step();
    drive_idle();
    IMemData = 16'hBEEF;
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b1) begin n_fail++; $display("FAIL load_fwd_we: got %0b expected 1", fwd_we); end
    n_checks++; if (fwd_rd !== 3'd5) begin n_fail++; $display("FAIL load_fwd_rd: got %0d expected 5", fwd_rd); end
    n_checks++; if (fwd_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_fwd_data: got %h expected beef", fwd_data); end
    n_checks++; if (rs2_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_bypass: got %h expected beef", rs2_data); end
    step();
    IMemData = 16'h0000;
    exp_retire = exp_retire + 16'd1;
    @(negedge clk);
    n_checks++; if (rs2_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_array: got %h expected beef", rs2_data); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL load_retire: got %h expected %h", retire_count, exp_retire); end
  endtask

  task automatic test_r0_write();
    drive_instr(1'b1, 1'b0, 16'hFFFF, 3'd0);
    rs1 = 3'd0;
    step();
    drive_idle();
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL r0_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL r0_bypass: got %h expected 0000", rs1_data); end
    step();
    exp_retire = exp_retire + 16'd1;
    @(negedge clk);
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL r0_array: got %h expected 0000", rs1_data); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL r0_retire: got %h expected %h", retire_count, exp_retire); end
  endtask

  task automatic test_load_stall();
    drive_instr(1'b1, 1'b1, 16'h0F0F, 3'd2);
    rs1 = 3'd2;
    step();
    drive_idle();
    IMemData = 16'hA5A5;
    stall = 1'b1;
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL stall1_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL stall1_state: got %0d expected RUN", dbg_state); end
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL stall1_rs1: got %h expected 0000", rs1_data); end
    step();
    IMemData = 16'h0000;
    @(negedge clk);
    n_checks++; if (dbg_state !== HELD) begin n_fail++; $display("FAIL stall2_state: got %0d expected HELD", dbg_state); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL stall2_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL stall2_retire: got %h expected %h", retire_count, exp_retire); end
    step();
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL stall3_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (dbg_state !== HELD) begin n_fail++; $display("FAIL stall3_state: got %0d expected HELD", dbg_state); end
    step();
    stall = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== HELD) begin n_fail++; $display("FAIL release_state: got %0d expected HELD", dbg_state); end
    n_checks++; if (fwd_we !== 1'b1) begin n_fail++; $display("FAIL release_fwd_we: got %0b expected 1", fwd_we); end
    n_checks++; if (fwd_rd !== 3'd2) begin n_fail++; $display("FAIL release_fwd_rd: got %0d expected 2", fwd_rd); end
    n_checks++; if (fwd_data !== 16'hA5A5) begin n_fail++; $display("FAIL release_fwd_data: got %h expected a5a5", fwd_data); end
    n_checks++; if (rs1_data !== 16'hA5A5) begin n_fail++; $display("FAIL release_bypass: got %h expected a5a5", rs1_data); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL release_retire_pre: got %h expected %h", retire_count, exp_retire); end
    step();
    exp_retire = exp_retire + 16'd1;
    @(negedge clk);
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL after_release_state: got %0d expected RUN", dbg_state); end
    n_checks++; if (rs1_data !== 16'hA5A5) begin n_fail++; $display("FAIL after_release_r2: got %h expected a5a5", rs1_data); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL after_release_retire: got %h expected %h", retire_count, exp_retire); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL after_release_fwd_we: got %0b expected 0", fwd_we); end
  endtask

  task automatic test_flush_stall();
    drive_instr(1'b1, 1'b0, 16'h0042, 3'd4);
    rs1 = 3'd4;
    step();
    drive_idle();
    flush = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL fs_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL fs_bypass: got %h expected 0000", rs1_data); end
    step();
    flush = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL fs_state: got %0d expected RUN", dbg_state); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL fs_after_we: got %0b expected 0", fwd_we); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL fs_retire: got %h expected %h", retire_count, exp_retire); end
    step();
    @(negedge clk);
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL fs_r4: got %h expected 0000", rs1_data); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL fs_retire2: got %h expected %h", retire_count, exp_retire); end
  endtask

  task automatic test_flush_in_held();
    drive_instr(1'b1, 1'b1, 16'h0000, 3'd6);
    rs1 = 3'd6;
    step();
    drive_idle();
    stall = 1'b1;
    IMemData = 16'h7777;
    step();
    IMemData = 16'h0000;
    flush = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_state !== HELD) begin n_fail++; $display("FAIL fh_state_pre: got %0d expected HELD", dbg_state); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL fh_fwd_we: got %0b expected 0", fwd_we); end
    step();
    flush = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL fh_state: got %0d expected RUN", dbg_state); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL fh_after_we: got %0b expected 0", fwd_we); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL fh_retire: got %h expected %h", retire_count, exp_retire); end
    step();
    @(negedge clk);
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL fh_r6: got %h expected 0000", rs1_data); end
  endtask

  task automatic test_back_to_back();
    drive_instr(1'b1, 1'b0, 16'h0001, 3'd7);
    rs1 = 3'd7;
    step();
    drive_instr(1'b1, 1'b0, 16'h0002, 3'd7);
    @(negedge clk);
    n_checks++; if (fwd_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 0001", fwd_data); end
    n_checks++; if (rs1_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_first_bypass: got %h expected 0001", rs1_data); end
    step();
    drive_idle();
    exp_retire = exp_retire + 16'd1;
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b1) begin n_fail++; $display("FAIL b2b_second_we: got %0b expected 1", fwd_we); end
    n_checks++; if (fwd_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 0002", fwd_data); end
    n_checks++; if (rs1_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_second_bypass: got %h expected 0002", rs1_data); end
    step();
    exp_retire = exp_retire + 16'd1;
    @(negedge clk);
    n_checks++; if (rs1_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_array: got %h expected 0002", rs1_data); end
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL b2b_retire: got %h expected %h", retire_count, exp_retire); end
  endtask

  task automatic test_counter_wrap();
    int n;
    n = 32'd65535 - int'(exp_retire);
    drive_instr(1'b0, 1'b0, 16'h0000, 3'd1);
    repeat (n) step();
    drive_idle();
    step();
    exp_retire = 16'hFFFF;
    @(negedge clk);
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL wrap_preset: got %h expected ffff", retire_count); end
    drive_instr(1'b0, 1'b0, 16'h0000, 3'd1);
    step();
    drive_idle();
    step();
    exp_retire = 16'h0000;
    @(negedge clk);
    n_checks++; if (retire_count !== exp_retire) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", retire_count); end
  endtask

  task automatic test_reset_mid_held();
    rs1 = 3'd2;
    rs2 = 3'd7;
    drive_instr(1'b1, 1'b1, 16'h0000, 3'd1);
    step();
    drive_idle();
    stall = 1'b1;
    IMemData = 16'h3C3C;
    step();
    @(negedge clk);
    n_checks++; if (dbg_state !== HELD) begin n_fail++; $display("FAIL rmh_state_pre: got %0d expected HELD", dbg_state); end
    n_checks++; if (rs1_data !== 16'hA5A5) begin n_fail++; $display("FAIL rmh_r2_pre: got %h expected a5a5", rs1_data); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL rmh_state: got %0d expected RUN", dbg_state); end
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL rmh_r2: got %h expected 0000", rs1_data); end
    n_checks++; if (rs2_data !== 16'h0000) begin n_fail++; $display("FAIL rmh_r7: got %h expected 0000", rs2_data); end
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL rmh_fwd_we: got %0b expected 0", fwd_we); end
    n_checks++; if (fwd_rd !== 3'd0) begin n_fail++; $display("FAIL rmh_fwd_rd: got %0d expected 0", fwd_rd); end
    n_checks++; if (fwd_data !== 16'h0000) begin n_fail++; $display("FAIL rmh_fwd_data: got %h expected 0000", fwd_data); end
    n_checks++; if (retire_count !== 16'h0000) begin n_fail++; $display("FAIL rmh_retire: got %h expected 0000", retire_count); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    rs1 = 3'd1;
    @(negedge clk);
    n_checks++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL rmh_after_we: got %0b expected 0", fwd_we); end
    step();
    @(negedge clk);
    n_checks++; if (rs1_data !== 16'h0000) begin n_fail++; $display("FAIL rmh_r1: got %h expected 0000", rs1_data); end
    n_checks++; if (retire_count !== 16'h0000) begin n_fail++; $display("FAIL rmh_retire_after: got %h expected 0000", retire_count); end
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    rs1      = 3'd0;
    rs2      = 3'd0;
    IMemData = 16'h0000;
    drive_idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_alu_wb();
    test_load_wb();
    test_r0_write();
    test_load_stall();
    test_flush_stall();
    test_flush_in_held();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
